lsu: RTL
========

Name: lsu

Overview:
- Load/store unit downstream of the ID-EX register. It consumes the decoder's lsu_req/lsu_we/lsu_operate plus the ALU-computed effective address and rs2 data.
- Runs a single-outstanding req/gnt/rvalid data-bus transaction, formats store data and byte enables, and aligns and extends load data.
- Returns load results to the register-file write-back port and holds the pipeline stalled while a transaction is in flight.

Parameters:
- ADDR_W, 32, effective/bus address width
- DATA_W, 32, bus data width; only 32 supported

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- lsu_req_i  in  1  memory operation request from ID-EX
- lsu_we_i  in  1  1=store, 0=load
- lsu_operate_i  in  milano_pkg::lsu_opt_e  LSU_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW; SB/SH/SW are added to the package
- lsu_addr_i  in  32  effective address (rs1+imm)
- lsu_wdata_i  in  32  rs2 data for stores
- lsu_rd_addr_i  in  5  load destination register
- lsu_busy_o  out  1  stall request to pipeline
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_addr_o  out  32  word-aligned bus address
- data_we_o  out  1  bus write
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  bus write data
- data_rvalid_i  in  1  bus response valid
- data_rdata_i  in  32  bus read data
- data_err_i  in  1  bus error, qualified by rvalid
- rd_wr_en_o  out  1  write-back enable, 1-cycle pulse
- rd_addr_o  out  5  write-back register
- rd_wdata_o  out  32  aligned/extended load data
- lsu_done_o  out  1  1-cycle pulse at operation completion
- misaligned_o  out  1  1-cycle pulse on misaligned access
- bus_err_o  out  1  1-cycle pulse on bus error (see optional feature)
- err_addr_o  out  32  address of last misaligned/errored access

Behaviour:
- Reset (rst_i=1 at a clk_i edge): state=IDLE. All outputs are 0, including data_be_o=4'h0 and err_addr_o=0. A reset mid-transaction abandons it; any rvalid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT_RV, WB.
- IDLE:
  - Accept when lsu_req_i=1 and lsu_operate_i!=LSU_NONE. On accept, register op, address, wdata and rd; misalignment is checked from the registered values.
  - lsu_req_i with LSU_NONE is ignored.
  - If aligned: go to REQ.
  - If misaligned: go to WB, no bus transaction; misaligned_o=1 and lsu_done_o=1 in WB, err_addr_o=address.
  - Misaligned means: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
- REQ:
  - data_req_o=1; data_addr_o={addr[31:2],2'b00}; data_we_o, data_be_o, data_wdata_o held stable until data_gnt_i=1.
  - On gnt go to WAIT_RV; data_req_o drops the next cycle.
- WAIT_RV: wait for data_rvalid_i. rvalid is never expected in the gnt cycle; if present it is ignored. On rvalid, capture formatted data and go to WB.
- WB (one cycle, then IDLE):
  - lsu_done_o=1.
  - For a load without error: rd_wr_en_o=1, rd_addr_o=rd, rd_wdata_o=result.
  - Stores never assert rd_wr_en_o.
- lsu_busy_o=1 in REQ, WAIT_RV and WB, 0 in IDLE. New lsu_req_i while busy is ignored; upstream must hold it until busy falls.
- Minimum latency, accept to WB: 3 cycles (accept, REQ with immediate gnt, rvalid next cycle).
- Store formatting (o = addr[1:0]):
  - SB: be=4'b0001<<o, wdata={4{wdata[7:0]}}
  - SH: be=4'b0011<<o, wdata={2{wdata[15:0]}}
  - SW: be=4'b1111, wdata unchanged
  - Loads: be=4'b1111, data_we_o=0.
- Load formatting: shifted=data_rdata_i>>(8*o).
  - LB: sign-extend shifted[7:0]
  - LBU: zero-extend shifted[7:0]
  - LH: sign-extend shifted[15:0]
  - LHU: zero-extend shifted[15:0]
  - LW: data_rdata_i

Optional Feature:
- Macro MILANO_LSU_BUS_ERR_EN.
- Defined: data_err_i is sampled with rvalid. On error, WB asserts bus_err_o=1 and lsu_done_o=1, suppresses rd_wr_en_o, and sets err_addr_o=address.
- Not defined: data_err_i is ignored, bus_err_o is tied 0, and loads write back data_rdata_i formatting regardless.

Test Plan:
- LW addr=0x100, gnt immediate, rvalid next cycle with rdata=0xDEADBEEF, rd=5 -> REQ addr 0x100, be=1111; WB cycle 3 after accept: rd_wr_en_o=1, rd_addr_o=5, rd_wdata_o=0xDEADBEEF; busy high exactly 3 cycles.
- LB addr=0x103, rdata=0x80FFFFFF -> rd_wdata_o=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102, rdata=0x8001_1234 -> 0x00008001.
- SB addr=0x201, wdata=0x000000AB -> data_addr_o=0x200, be=0010, data_wdata_o=0xABABABAB, we=1; gnt delayed 3 cycles -> all bus outputs stable throughout; no rd_wr_en_o.
- LW addr=0x102 -> no data_req_o ever; misaligned_o and lsu_done_o pulse 1 cycle after accept; err_addr_o=0x102; SH addr=0x301 -> same behaviour.
- rst_i asserted in WAIT_RV -> next cycle IDLE, all outputs 0; rvalid arriving afterwards produces no rd_wr_en_o; new LW accepted normally.
- With MILANO_LSU_BUS_ERR_EN: LW with rvalid and data_err_i=1 at addr 0x400 -> bus_err_o=1, rd_wr_en_o=0, err_addr_o=0x400. Without the macro, the same stimulus -> rd_wr_en_o=1, bus_err_o=0.

Source files
------------

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: single-outstanding req/gnt/rvalid bus master with store formatting and load alignment.
// Optional bus-error reporting is enabled by defining MILANO_LSU_BUS_ERR_EN.
package milano_pkg;
    typedef enum logic [3:0] {
        LSU_NONE,
        LSU_LB,
        LSU_LH,
        LSU_LW,
        LSU_LBU,
        LSU_LHU,
        LSU_SB,
        LSU_SH,
        LSU_SW
    } lsu_opt_e;
endpackage

module lsu
    import milano_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  lsu_opt_e          lsu_operate_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    input  logic [4:0]        lsu_rd_addr_i,
    output logic              lsu_busy_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    input  logic              data_err_i,
    output logic              rd_wr_en_o,
    output logic [4:0]        rd_addr_o,
    output logic [DATA_W-1:0] rd_wdata_o,
    output logic              lsu_done_o,
    output logic              misaligned_o,
    output logic              bus_err_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RV, S_WB} state_e;

    state_e            state_q, state_d;
    lsu_opt_e          op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] err_addr_q;
    logic              err_q;

    // Direction comes from the operation code; lsu_we_i is redundant with it.
    logic unused_we;
    assign unused_we = lsu_we_i;

    function automatic logic is_misaligned(input lsu_opt_e op, input logic [1:0] lo);
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: is_misaligned = lo[0];
            LSU_LW, LSU_SW:          is_misaligned = (lo != 2'b00);
            default:                 is_misaligned = 1'b0;
        endcase
    endfunction

    logic accept, mis_in, mis_q, is_store, is_load;
    assign accept   = (state_q == S_IDLE) && lsu_req_i && (lsu_operate_i != LSU_NONE);
    assign mis_in   = is_misaligned(lsu_operate_i, lsu_addr_i[1:0]);
    assign mis_q    = is_misaligned(op_q, addr_q[1:0]);
    assign is_store = (op_q == LSU_SB) || (op_q == LSU_SH) || (op_q == LSU_SW);
    assign is_load  = (op_q != LSU_NONE) && !is_store;

    logic [DATA_W-1:0] shifted, load_fmt;
    assign shifted = data_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_fmt = data_rdata_i;
        case (op_q)
            LSU_LB:  load_fmt = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            LSU_LBU: load_fmt = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            LSU_LH:  load_fmt = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            LSU_LHU: load_fmt = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: load_fmt = data_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = mis_in ? S_WB : S_REQ;
            S_REQ:     if (data_gnt_i) state_d = S_WAIT_RV;
            S_WAIT_RV: if (data_rvalid_i) state_d = S_WB;
            S_WB:      state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            op_q       <= LSU_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rdata_q    <= '0;
            err_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= lsu_operate_i;
                addr_q  <= lsu_addr_i;
                wdata_q <= lsu_wdata_i;
                rd_q    <= lsu_rd_addr_i;
                if (mis_in) err_addr_q <= lsu_addr_i;
            end
            if (state_q == S_WAIT_RV && data_rvalid_i) begin
                rdata_q <= load_fmt;
`ifdef MILANO_LSU_BUS_ERR_EN
                if (data_err_i) err_addr_q <= addr_q;
`endif
            end
        end
    end

`ifdef MILANO_LSU_BUS_ERR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            err_q <= 1'b0;
        else if (state_q == S_WAIT_RV && data_rvalid_i)
            err_q <= data_err_i;
    end
`else
    logic unused_err;
    assign unused_err = data_err_i;
    assign err_q      = 1'b0;
`endif

    always_comb begin
        lsu_busy_o   = (state_q != S_IDLE);
        data_req_o   = 1'b0;
        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = 4'h0;
        data_wdata_o = '0;
        rd_wr_en_o   = 1'b0;
        rd_addr_o    = '0;
        rd_wdata_o   = '0;
        lsu_done_o   = 1'b0;
        misaligned_o = 1'b0;
        bus_err_o    = 1'b0;
        case (state_q)
            S_REQ: begin
                data_req_o  = 1'b1;
                data_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
                data_we_o   = is_store;
                case (op_q)
                    LSU_SB: begin
                        data_be_o    = 4'b0001 << addr_q[1:0];
                        data_wdata_o = {4{wdata_q[7:0]}};
                    end
                    LSU_SH: begin
                        data_be_o    = 4'b0011 << addr_q[1:0];
                        data_wdata_o = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        data_be_o    = 4'b1111;
                        data_wdata_o = wdata_q;
                    end
                endcase
            end
            S_WB: begin
                lsu_done_o   = 1'b1;
                misaligned_o = mis_q;
                bus_err_o    = err_q;
                if (is_load && !mis_q && !err_q) begin
                    rd_wr_en_o = 1'b1;
                    rd_addr_o  = rd_q;
                    rd_wdata_o = rdata_q;
                end
            end
            default: ;
        endcase
    end

    assign err_addr_o = err_addr_q;

endmodule
